code_expander: RTL and testbench
================================

// Module: code_expander
// PURPOSE
//  Transmit-side counterpart of the 4-in/2-out code FSM: accepts 2-bit codes over a
//  valid/ready handshake and expands each one to a timed 4-bit one-hot word stream.
//  A small FIFO decouples the producer from output timing.
//  Sits upstream of the 4-bit IN bus of the code FSM; used as its stimulus/loopback source.
// PARAMETERS
//  DEPTH  4  FIFO entries, power of 2, >=2
//  HOLD   3  cycles each word is driven with WORD_VALID=1, >=1
//  GAP    1  idle cycles (WORD=0, WORD_VALID=0) after each word, >=0
// PORTS
//  CLK         in   1               clock, all logic on rising edge
//  RST         in   1               synchronous reset, active-high
//  CODE        in   2               code to transmit
//  CODE_VALID  in   1               CODE is valid this cycle
//  CODE_READY  out  1               FIFO can accept; transfer when VALID&&READY at edge
//  WORD        out  4               one-hot expansion of current code, 0 when idle
//  WORD_VALID  out  1               WORD holds a live code
//  BUSY        out  1               FSM not IDLE or FIFO not empty
//  LEVEL       out  $clog2(DEPTH)+1 FIFO occupancy
// BEHAVIOUR
//  - Reset (RST=1 at edge): FIFO emptied, LEVEL=0, state=IDLE, WORD=0, WORD_VALID=0,
//    counters=0. CODE_READY=0 while RST=1. Reset mid-word aborts the word; queued codes lost.
//  - CODE_READY = !RST && (LEVEL < DEPTH), combinational. No bypass: a full FIFO refuses even
//    if a pop happens the same cycle.
//  - Push and pop in one cycle: LEVEL unchanged, both take effect.
//  - Pointers wrap modulo DEPTH; LEVEL saturates at DEPTH only by the handshake, never by
//    silent drop.
//  - Decode: WORD = 4'b0001 << CODE (00->0001, 01->0010, 10->0100, 11->1000). All registered.
//  - FSM states:
//    IDLE: if LEVEL>0, pop the head, WORD<=decode(head), WORD_VALID<=1, cnt<=HOLD-1,
//          go to HOLD.
//    HOLD: if cnt>0, cnt--. At cnt==0: if GAP>0 -> WORD<=0, WORD_VALID<=0, cnt<=GAP-1,
//          go to GAP. If GAP==0 and LEVEL>0 -> pop, load next word, stay in HOLD
//          (back-to-back). Otherwise WORD<=0, WORD_VALID<=0, go to IDLE.
//    GAP:  if cnt>0, cnt--. At cnt==0: if LEVEL>0, pop and load (-> HOLD), else -> IDLE.
//  - Latency: code accepted at edge N into an empty FIFO with FSM in IDLE -> WORD valid
//    after edge N+1. It is held exactly HOLD cycles.
//  - Per-word period is HOLD+GAP cycles; sustained throughput is 1 code per HOLD+GAP.
//  - CODE is ignored when CODE_VALID=0 or CODE_READY=0. Codes are emitted in strict FIFO order.
// STRUCTURE
//  - Package code_expander_pkg:
//    state_t enum {IDLE,HOLD,GAP}
//    function decode(logic [1:0]) -> logic [3:0]
//    localparams for widths
//  - Sub-module code_fifo #(DEPTH,W=2): sync FIFO with push/pop/full/empty/level, sync
//    active-high reset.
//  - Top: FIFO instance, FSM, down-counter of width $clog2(max(HOLD,GAP,1))+1.
// TESTING
//  - Single code: push 2'b10 at cycle 0 -> WORD=0100,VALID=1 cycles 1-3; WORD=0 cycle 4;
//    IDLE cycle 5, BUSY=0.
//  - Burst: push 00,01,10,11 back-to-back -> words 0001,0010,0100,1000 each 3 cycles, with a
//    1-cycle gap between; LEVEL peaks at 3.
//  - Full: hold CODE_VALID=1 for 8 cycles, FIFO not draining -> CODE_READY=0 once LEVEL=4;
//    no code lost or duplicated.
//  - GAP=0, HOLD=1 build: push 4 codes -> 4 consecutive cycles of distinct valid words,
//    no zero between.
//  - Reset mid-operation: RST at 2nd HOLD cycle with LEVEL=2 -> next cycle WORD=0, VALID=0,
//    LEVEL=0, READY=1 after RST drops.
//  - Simultaneous push/pop at LEVEL=1 -> LEVEL stays 1; order preserved (scoreboard vs. queue).

Source files
------------

// File: rtl/code_expander_pkg.sv
// Shared types and helpers for the code expander: state encoding, code/word widths,
// the code-to-one-hot decode and the hold/gap counter width.
package code_expander_pkg;

   localparam int unsigned CodeW = 2;
   localparam int unsigned WordW = 4;

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StGap
   } state_t;

   // 2-bit code to one-hot word: 00->0001, 01->0010, 10->0100, 11->1000
   function automatic logic [WordW-1:0] decode(input logic [CodeW-1:0] code);
      decode = 4'b0001 << code;
   endfunction

   // Down-counter must hold max(hold, gap, 1) - 1; one spare bit keeps the
   // width sane for hold = gap = 1.
   function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
      int unsigned m;
      m = 1;
      if (hold > m) m = hold;
      if (gap > m) m = gap;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/code_fifo.sv
// Synchronous FIFO, power-of-two depth, with occupancy count. Push when full and pop
// when empty are ignored so the level can never wrap.
module code_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LvlW = PtrW + 1;
   localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);

   logic [W-1:0]    mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [LvlW-1:0] level_q;
   logic [LvlW-1:0] level_d;
   logic            do_push;
   logic            do_pop;

   assign full    = (level_q == FullLvl);
   assign empty   = (level_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];
   assign level   = level_q;

   // Occupancy next-state: simultaneous push and pop leave it unchanged
   always_comb begin
      level_d = level_q;
      if (do_push && !do_pop) begin
         level_d = level_q + LvlW'(1);
      end else if (do_pop && !do_push) begin
         level_d = level_q - LvlW'(1);
      end
   end

   // Storage array, no reset needed: contents are only read below the level
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Pointers wrap naturally modulo DEPTH
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/code_expander.sv
// Accepts 2-bit codes over valid/ready into a small FIFO and plays each one out as a
// one-hot word held for HOLD cycles followed by GAP idle cycles.
module code_expander
   import code_expander_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned HOLD  = 3,
   parameter int unsigned GAP   = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             code,
   input  logic                   code_valid,
   output logic                   code_ready,
   output logic [3:0]             word,
   output logic                   word_valid,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned CntW = cnt_width(HOLD, GAP);
   localparam logic [CntW-1:0] HoldLd = CntW'(HOLD - 1);
   localparam logic [CntW-1:0] GapLd  = CntW'((GAP > 0) ? GAP - 1 : 0);

   state_t          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      word_q, word_d;
   logic            word_valid_q, word_valid_d;

   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [1:0]      fifo_dout;

   // No bypass: a full FIFO refuses even when the FSM pops in the same cycle
   assign code_ready = !rst && !fifo_full;
   assign push       = code_valid && code_ready;

   code_fifo #(
      .DEPTH (DEPTH),
      .W     (CodeW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (code),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // Next-state, counter and word/pop decisions
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      word_d       = word_q;
      word_valid_d = word_valid_q;
      pop          = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop          = 1'b1;
               word_d       = decode(fifo_dout);
               word_valid_d = 1'b1;
               cnt_d        = HoldLd;
               state_d      = StHold;
            end
         end
         StHold: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else if (GAP > 0) begin
               word_d       = '0;
               word_valid_d = 1'b0;
               cnt_d        = GapLd;
               state_d      = StGap;
            end else if (!fifo_empty) begin
               // Back-to-back words when there is no gap
               pop          = 1'b1;
               word_d       = decode(fifo_dout);
               word_valid_d = 1'b1;
               cnt_d        = HoldLd;
            end else begin
               word_d       = '0;
               word_valid_d = 1'b0;
               state_d      = StIdle;
            end
         end
         StGap: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else if (!fifo_empty) begin
               pop          = 1'b1;
               word_d       = decode(fifo_dout);
               word_valid_d = 1'b1;
               cnt_d        = HoldLd;
               state_d      = StHold;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM and output registers; reset aborts any word in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign word       = word_q;
   assign word_valid = word_valid_q;
   assign busy       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_code_expander.sv
// Bench for code_expander: cycle tables for single code and burst, hand sequences for
// full FIFO, reset mid-word and a HOLD=1/GAP=0 build, plus word-order scoreboards.
module tb_code_expander;

   localparam int HOLD1 = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] code = 2'd0;
   logic       code_valid = 1'b0;
   logic       code_ready;
   logic [3:0] word;
   logic       word_valid;
   logic       busy;
   logic [2:0] level;

   logic [1:0] code2 = 2'd0;
   logic       code_valid2 = 1'b0;
   logic       code_ready2;
   logic [3:0] word2;
   logic       word_valid2;
   logic       busy2;
   logic [2:0] level2;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [3:0] sb1 [$];
   logic [3:0] sb2 [$];
   int run1 = 0;
   int words1 = 0;
   logic prev_valid1 = 1'b0;

   always #5 clk = ~clk;

   code_expander #(.DEPTH(4), .HOLD(HOLD1), .GAP(1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .word       (word),
      .word_valid (word_valid),
      .busy       (busy),
      .level      (level)
   );

   code_expander #(.DEPTH(4), .HOLD(1), .GAP(0)) u_dut2 (
      .clk        (clk),
      .rst        (rst),
      .code       (code2),
      .code_valid (code_valid2),
      .code_ready (code_ready2),
      .word       (word2),
      .word_valid (word_valid2),
      .busy       (busy2),
      .level      (level2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard for the HOLD=3 instance: one pop per word start, runs must be HOLD long
   always @(negedge clk) begin
      logic [3:0] e;
      if (code_valid && code_ready) sb1.push_back(4'b0001 << code);
      if (word_valid) begin
         if (run1 == 0) begin
            e = (sb1.size() > 0) ? sb1.pop_front() : 4'h0;
            check("sb1_word", 32'(word), 32'(e));
            words1++;
         end
         run1 = (run1 + 1) % HOLD1;
      end else if (prev_valid1) begin
         check("sb1_hold_len", 32'(run1), 32'd0);
      end
      if (rst) begin
         sb1.delete();
         run1 = 0;
      end
      prev_valid1 = word_valid;
   end

   // Scoreboard for the HOLD=1 instance: every valid cycle is a new word
   always @(negedge clk) begin
      logic [3:0] e;
      if (code_valid2 && code_ready2) sb2.push_back(4'b0001 << code2);
      if (word_valid2) begin
         e = (sb2.size() > 0) ? sb2.pop_front() : 4'h0;
         check("sb2_word", 32'(word2), 32'(e));
      end
      if (rst) sb2.delete();
   end

   typedef struct packed {
      logic       cv;
      logic [1:0] code;
      logic [3:0] w;
      logic       wv;
      logic       busy;
      logic [2:0] lvl;
      logic       rdy;
   } vec_t;

   function automatic vec_t mk(input logic cv, input logic [1:0] c, input logic [3:0] w,
                               input logic wv, input logic b, input logic [2:0] l);
      vec_t v;
      v.cv = cv; v.code = c; v.w = w; v.wv = wv; v.busy = b; v.lvl = l; v.rdy = 1'b1;
      return v;
   endfunction

   vec_t vecs [$];
   logic [2:0] lv_exp [8] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd4};
   logic [4:0] exp2 [6] = '{5'b0000_0, 5'b0001_1, 5'b0010_1, 5'b0100_1, 5'b1000_1, 5'b0000_0};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int acc_before;
      int words_before;
      logic acc;
      bit done;

      // Single code 10: outputs after each edge
      vecs.push_back(mk(1'b1, 2'd2, 4'b0000, 1'b0, 1'b1, 3'd1));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 2'd0, 4'b0100, 1'b1, 1'b1, 3'd0));
      vecs.push_back(mk(1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 3'd0));
      vecs.push_back(mk(1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0));
      // Burst 00,01,10,11; edge 1 is a push and pop at level 1
      vecs.push_back(mk(1'b1, 2'd0, 4'b0000, 1'b0, 1'b1, 3'd1));
      vecs.push_back(mk(1'b1, 2'd1, 4'b0001, 1'b1, 1'b1, 3'd1));
      vecs.push_back(mk(1'b1, 2'd2, 4'b0001, 1'b1, 1'b1, 3'd2));
      vecs.push_back(mk(1'b1, 2'd3, 4'b0001, 1'b1, 1'b1, 3'd3));
      vecs.push_back(mk(1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 3'd3));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 3'd2));
      vecs.push_back(mk(1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 3'd2));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 2'd0, 4'b0100, 1'b1, 1'b1, 3'd1));
      vecs.push_back(mk(1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 3'd1));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 2'd0, 4'b1000, 1'b1, 1'b1, 3'd0));
      vecs.push_back(mk(1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 3'd0));
      vecs.push_back(mk(1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 3'd0));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(code_ready), 32'd0);
      check("rst_state", 32'({word, word_valid, busy, level}), 32'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(code_ready), 32'd1);

      // Table-driven single code and burst
      foreach (vecs[i]) begin
         code_valid = vecs[i].cv;
         code       = vecs[i].code;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i),
               32'({word, word_valid, busy, level, code_ready}),
               32'({vecs[i].w, vecs[i].wv, vecs[i].busy, vecs[i].lvl, vecs[i].rdy}));
      end
      code_valid = 1'b0;

      // Full FIFO: valid held 8 cycles, code only advances when accepted
      idx = 0;
      acc_before = 0;
      words_before = words1;
      for (int k = 0; k < 8; k++) begin
         code       = 2'(3 - (idx % 4));
         code_valid = 1'b1;
         acc        = code_ready;
         @(posedge clk);
         #1;
         check($sformatf("full_level%0d", k), 32'(level), 32'(lv_exp[k]));
         check($sformatf("full_ready%0d", k), 32'(code_ready), 32'(lv_exp[k] != 3'd4));
         if (acc) idx++;
      end
      code_valid = 1'b0;
      check("full_accepted", 32'(idx), 32'd6);
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(posedge clk);
         #1;
         if (!busy) done = 1'b1;
      end
      check("full_drain_done", 32'(busy), 32'd0);
      check("full_words", 32'(words1 - words_before), 32'd6);
      check("full_sb_empty", 32'(sb1.size()), 32'd0);

      // Reset during the second HOLD cycle with two codes queued
      for (int k = 0; k < 3; k++) begin
         code_valid = 1'b1;
         code       = 2'(k);
         @(posedge clk);
         #1;
      end
      check("mid_level", 32'(level), 32'd2);
      check("mid_word", 32'({word, word_valid}), 32'({4'b0001, 1'b1}));
      code_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'(code_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("mid_after_rst", 32'({word, word_valid, level, busy}), 32'd0);
      check("mid_ready", 32'(code_ready), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("mid_no_leftover", 32'({word_valid, busy}), 32'd0);

      // HOLD=1, GAP=0 build: four consecutive distinct words
      for (int k = 0; k < 6; k++) begin
         code_valid2 = (k < 4);
         code2       = 2'(k);
         @(posedge clk);
         #1;
         check($sformatf("b2b%0d", k), 32'({word2, word_valid2}), 32'(exp2[k]));
      end
      code_valid2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("b2b_idle", 32'(busy2), 32'd0);
      check("sb2_empty", 32'(sb2.size()), 32'd0);
      check("sb1_final_empty", 32'(sb1.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
